// File: rtl/sd_dat0_block_rx.sv
// SD DAT0 single-block receiver: start-bit hunt, MSB-first byte deserialiser, CRC16 and end-bit check.
// Latency: outen 1 clk after a byte's last sdclk sample; done 1 clk after the end-bit (or timeout) sample.
// No backpressure: bytes are strobed out as they arrive; start is ignored while rbusy.
module sd_dat0_block_rx #(
  parameter int BLOCK_BYTES   = 512,
  parameter int TIMEOUT_EDGES = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sdclk,
  input  logic        sddat0,
  input  logic        start,
  output logic        rbusy,
  output logic        outen,
  output logic [11:0] outaddr,
  output logic [7:0]  outbyte,
  output logic        done,
  output logic        crc_ok,
  output logic        timeout
);

  localparam int EW = $clog2(TIMEOUT_EDGES + 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(TIMEOUT_EDGES - 1);
  localparam logic [11:0]   BYTE_LAST = 12'(BLOCK_BYTES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CRC   = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  logic [2:0]    state;
  logic          sdclkl;
  logic          sample;
  logic [EW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic [11:0]   byte_cnt;
  logic [6:0]    shreg;
  logic [15:0]   crc;
  logic [15:0]   rx_crc;

  // Serial CCITT step, x^16+x^12+x^5+1, one data bit in.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = d ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Rising sdclk seen in the clk domain marks the cycle in which DAT0 is sampled.
  assign sample = ~sdclkl & sdclk;
  assign rbusy  = (state != ST_IDLE);

  // Registered copy of sdclk for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sdclkl <= 1'b0;
    else       sdclkl <= sdclk;
  end

  // Receive FSM: start-bit hunt, data bytes, received CRC, end bit; pulses are single-clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      edge_cnt <= '0;
      bit_cnt  <= 4'd0;
      byte_cnt <= 12'd0;
      shreg    <= 7'd0;
      crc      <= 16'h0000;
      rx_crc   <= 16'h0000;
      outen    <= 1'b0;
      outaddr  <= 12'd0;
      outbyte  <= 8'd0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      outen <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT;
            edge_cnt <= '0;
            crc      <= 16'h0000;
            crc_ok   <= 1'b0;
            timeout  <= 1'b0;
            outaddr  <= 12'd0;
          end
        end
        ST_WAIT: begin
          if (sample) begin
            if (!sddat0) begin
              // Start bit found; it is framing only and stays out of the CRC.
              state    <= ST_DATA;
              bit_cnt  <= 4'd0;
              byte_cnt <= 12'd0;
            end else if (edge_cnt == EDGE_LAST) begin
              state   <= ST_IDLE;
              done    <= 1'b1;
              timeout <= 1'b1;
              crc_ok  <= 1'b0;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg <= {shreg[5:0], sddat0};
            crc   <= crc_step(crc, sddat0);
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= 4'd0;
              outbyte  <= {shreg, sddat0};
              outaddr  <= byte_cnt;
              outen    <= 1'b1;
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == BYTE_LAST) state <= ST_CRC;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_CRC: begin
          // Running CRC is frozen here; only the card's CRC is shifted in.
          if (sample) begin
            rx_crc  <= {rx_crc[14:0], sddat0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd15) state <= ST_END;
          end
        end
        ST_END: begin
          if (sample) begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            crc_ok  <= (rx_crc == crc) && sddat0;
            timeout <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat0_block_rx.sv
// Bench for sd_dat0_block_rx: directed blocks driven bit by bit, scoreboard queues checked by a monitor.
// Stimulus pushes expected bytes/done results; the monitor pops on outen/done at the falling clk edge.
// sdclk runs at clk/2; DAT0 changes while sdclk is low.
module tb_sd_dat0_block_rx;

  localparam int NB = 512;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sdclk = 1'b1;
  logic        sddat0 = 1'b1;
  logic        start = 1'b0;
  logic        rbusy, outen, done, crc_ok, timeout;
  logic [11:0] outaddr;
  logic [7:0]  outbyte;

  int errors = 0;
  int checks = 0;

  logic [19:0] exp_bytes[$];
  logic [1:0]  exp_done[$];

  sd_dat0_block_rx #(.BLOCK_BYTES(NB), .TIMEOUT_EDGES(100)) dut (
    .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat0(sddat0), .start(start),
    .rbusy(rbusy), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .done(done), .crc_ok(crc_ok), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (outen) begin
        if (exp_bytes.size() == 0) chk("unexpected_outen", {20'd0, outaddr}, 32'hFFFFFFFF);
        else begin
          logic [19:0] e;
          e = exp_bytes.pop_front();
          chk("outaddr", {20'd0, outaddr}, {20'd0, e[19:8]});
          chk("outbyte", {24'd0, outbyte}, {24'd0, e[7:0]});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", {30'd0, crc_ok, timeout}, 32'hFFFFFFFF);
        else begin
          logic [1:0] d;
          d = exp_done.pop_front();
          chk("crc_ok", {31'd0, crc_ok}, {31'd0, d[1]});
          chk("timeout", {31'd0, timeout}, {31'd0, d[0]});
          chk("rbusy_at_done", {31'd0, rbusy}, 32'd0);
        end
      end
    end
  end

  function automatic logic [7:0] dbyte(input int mode, input int i);
    logic [31:0] v;
    v = i;
    return (mode == 1) ? v[7:0] : 8'hFF;
  endfunction

  function automatic logic [15:0] crc_model(input int mode);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < NB; i++) begin
      b = dbyte(mode, i);
      for (int k = 7; k >= 0; k--) begin
        fb = b[k] ^ c[15];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sddat0 = b;
    sdclk  = 1'b0;
    @(negedge clk);
    sdclk  = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_done.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_bytes.size() + exp_done.size(), 32'd0);
  endtask

  // One block; abort_at >= 0 stops after that many bytes and pulses reset.
  task automatic run_block(input string name, input int mode, input logic [15:0] crcv,
                           input logic endb, input logic exp_ok, input int abort_at,
                           input bit dbl_start);
    logic [7:0] b;
    int nb;
    nb = (abort_at >= 0) ? abort_at : NB;
    for (int i = 0; i < nb; i++) exp_bytes.push_back({12'(i), dbyte(mode, i)});
    if (abort_at < 0) exp_done.push_back({exp_ok, 1'b0});
    pulse_start();
    chk({name, "_rbusy"}, {31'd0, rbusy}, 32'd1);
    repeat (3) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      if (dbl_start && i == 10) pulse_start();
      b = dbyte(mode, i);
      for (int k = 7; k >= 0; k--) send_bit(b[k]);
    end
    if (abort_at >= 0) begin
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("abort_outs", {rbusy, outen, outaddr, outbyte, done, crc_ok, timeout}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      drain({name, "_abort"});
    end else begin
      for (int k = 15; k >= 0; k--) send_bit(crcv[k]);
      send_bit(endb);
      drain(name);
      chk({name, "_idle"}, {31'd0, rbusy}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {rbusy, outen, outaddr, outbyte, done, crc_ok, timeout}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_block("ff_good", 0, 16'h7FA1, 1'b1, 1'b1, -1, 1'b0);
    run_block("idx_good", 1, crc_model(1), 1'b1, 1'b1, -1, 1'b0);
    run_block("ff_badcrc", 0, 16'h7FA0, 1'b1, 1'b0, -1, 1'b0);
    run_block("ff_badend", 0, 16'h7FA1, 1'b0, 1'b0, -1, 1'b0);

    // Timeout: DAT0 held high for exactly 100 sdclk edges.
    exp_done.push_back(2'b01);
    pulse_start();
    for (int i = 0; i < 99; i++) send_bit(1'b1);
    @(negedge clk);
    chk("to_no_early_done", {31'd0, done}, 32'd0);
    chk("to_busy_at_99", {31'd0, rbusy}, 32'd1);
    sddat0 = 1'b1;
    sdclk  = 1'b0;
    @(negedge clk);
    sdclk  = 1'b1;
    @(negedge clk);
    chk("to_done_latency", {29'd0, done, timeout, crc_ok}, 32'b110);
    // Static sdclk afterwards: flags must hold, nothing else happens.
    repeat (4) @(negedge clk);
    chk("to_held", {29'd0, rbusy, timeout, crc_ok}, 32'b010);
    drain("timeout");

    run_block("dbl_start", 1, crc_model(1), 1'b1, 1'b1, -1, 1'b1);
    run_block("abort200", 1, 16'h0000, 1'b1, 1'b0, 200, 1'b0);
    run_block("after_reset", 1, crc_model(1), 1'b1, 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
